// File: rtl/div_scheduler_if.sv
// Requester, result and divider-control signals of div_scheduler.
// slave: the scheduler. master: the requesters plus the shared divider.
interface div_scheduler_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] dividend0;
  logic [WIDTH-1:0] divisor0;
  logic [WIDTH-1:0] dividend1;
  logic [WIDTH-1:0] divisor1;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             dz;
  logic             busy;
  logic             div_rst;
  logic             div_run;
  logic [WIDTH-1:0] div_dividend;
  logic [WIDTH-1:0] div_divisor;
  logic             div_ready;
  logic [WIDTH-1:0] div_quotient;
  logic [WIDTH-1:0] div_remainder;

  modport slave (
    input  req0, req1, dividend0, divisor0, dividend1, divisor1,
    input  div_ready, div_quotient, div_remainder,
    output gnt0, gnt1, done0, done1, quotient, remainder, dz, busy,
    output div_rst, div_run, div_dividend, div_divisor
  );

  modport master (
    output req0, req1, dividend0, divisor0, dividend1, divisor1,
    output div_ready, div_quotient, div_remainder,
    input  gnt0, gnt1, done0, done1, quotient, remainder, dz, busy,
    input  div_rst, div_run, div_dividend, div_divisor
  );
endinterface

// File: rtl/div_scheduler.sv
// Round-robin scheduler sharing one iterative divider between two requesters.
// Optional macro DIV_ZERO_CHK_EN: divisor==0 is answered locally without the divider.
module div_scheduler #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          TIE_FIRST = 1'b0
) (
  input logic            clk,
  input logic            rst,
  div_scheduler_if.slave bus
);

`ifdef DIV_ZERO_CHK_EN
  localparam bit ZERO_CHK = 1'b1;
`else
  localparam bit ZERO_CHK = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic             owner;
  logic             last;
  logic             dz_q;
  logic             pick;
  logic [WIDTH-1:0] pick_dividend;
  logic [WIDTH-1:0] pick_divisor;

  // Arbitration: a lone request wins, a tie goes to the port not served last.
  always_comb begin
    pick = bus.req1;
    if (bus.req0 && bus.req1) begin
      pick = ~last;
    end
    pick_dividend = pick ? bus.dividend1 : bus.dividend0;
    pick_divisor  = pick ? bus.divisor1  : bus.divisor0;
  end

  assign bus.dz = ZERO_CHK ? dz_q : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      owner            <= 1'b0;
      last             <= ~TIE_FIRST;
      dz_q             <= 1'b0;
      bus.gnt0         <= 1'b0;
      bus.gnt1         <= 1'b0;
      bus.done0        <= 1'b0;
      bus.done1        <= 1'b0;
      bus.busy         <= 1'b0;
      bus.div_rst      <= 1'b1;
      bus.div_run      <= 1'b0;
      bus.div_dividend <= '0;
      bus.div_divisor  <= '0;
      bus.quotient     <= '0;
      bus.remainder    <= '0;
    end else begin
      bus.gnt0  <= 1'b0;
      bus.gnt1  <= 1'b0;
      bus.done0 <= 1'b0;
      bus.done1 <= 1'b0;
      unique case (state)
        IDLE: begin
          bus.div_rst <= 1'b0;
          bus.div_run <= 1'b0;
          if (bus.req0 || bus.req1) begin
            owner    <= pick;
            bus.gnt0 <= ~pick;
            bus.gnt1 <= pick;
            bus.busy <= 1'b1;
            if (ZERO_CHK && (pick_divisor == '0)) begin
              // Divide-by-zero answered here; divider is left alone.
              state         <= DONE;
              bus.done0     <= ~pick;
              bus.done1     <= pick;
              bus.quotient  <= '1;
              bus.remainder <= pick_dividend;
              dz_q          <= 1'b1;
            end else begin
              state            <= LOAD;
              bus.div_rst      <= 1'b1;
              bus.div_dividend <= pick_dividend;
              bus.div_divisor  <= pick_divisor;
            end
          end
        end
        LOAD: begin
          state       <= RUN;
          bus.div_rst <= 1'b0;
          bus.div_run <= 1'b1;
        end
        RUN: begin
          if (bus.div_ready) begin
            state         <= DONE;
            bus.div_run   <= 1'b0;
            bus.quotient  <= bus.div_quotient;
            bus.remainder <= bus.div_remainder;
            dz_q          <= 1'b0;
            bus.done0     <= ~owner;
            bus.done1     <= owner;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          last     <= owner;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_scheduler.sv
// Directed self-checking bench for div_scheduler; the bench also plays the divider.
module tb_div_scheduler;

`ifdef DIV_ZERO_CHK_EN
  localparam bit ZC = 1'b1;
`else
  localparam bit ZC = 1'b0;
`endif

  typedef struct {
    bit          p;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] q;
    logic [31:0] r;
    bit          dz;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs [7];

  div_scheduler_if #(.WIDTH(32)) bus ();

  div_scheduler #(.WIDTH(32), .TIE_FIRST(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_req(input bit p, input bit v, input logic [31:0] a, input logic [31:0] b);
    if (p) begin
      bus.req1 = v; bus.dividend1 = a; bus.divisor1 = b;
    end else begin
      bus.req0 = v; bus.dividend0 = a; bus.divisor0 = b;
    end
  endtask

  task automatic wait_gnt(output bit p, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.gnt0 || bus.gnt1) && n < 20);
    chk("gnt_seen", 32'(bus.gnt0 | bus.gnt1), 32'd1);
    chk("gnt_onehot", 32'(bus.gnt0 & bus.gnt1), 32'd0);
    p = bus.gnt1;
  endtask

  // Called at the LOAD negedge (or DONE negedge on the zero path); ends one cycle after done.
  task automatic finish_op(input bit p, input int lat, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er, input bit edz,
                           input bit zpath, input bit stray, input bit raise1);
    if (zpath) begin
      chk("zero_skip_divider", 32'({bus.div_rst, bus.div_run}), 32'd0);
    end else begin
      chk("load_ctrl", 32'({bus.div_rst, bus.div_run}), 32'b10);
      chk("load_dividend", bus.div_dividend, a);
      chk("load_divisor", bus.div_divisor, b);
      if (stray) bus.div_ready = 1'b1;
      @(negedge clk);
      bus.div_ready = 1'b0;
      chk("run_ctrl", 32'({bus.div_rst, bus.div_run}), 32'b01);
      if (raise1) set_req(1'b1, 1'b1, 32'd1000, 32'd10);
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        chk("run_wait", 32'({bus.div_run, bus.done0, bus.done1, bus.gnt0, bus.gnt1}), 32'b10000);
      end
      bus.div_ready     = 1'b1;
      bus.div_quotient  = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      bus.div_remainder = (b == 32'd0) ? a : a % b;
      @(negedge clk);
      bus.div_ready     = 1'b0;
      bus.div_quotient  = 32'hDEAD_BEEF;
      bus.div_remainder = 32'hDEAD_BEEF;
    end
    chk("done_pulse", 32'({bus.done0, bus.done1}), p ? 32'b01 : 32'b10);
    chk("quotient", bus.quotient, eq);
    chk("remainder", bus.remainder, er);
    chk("dz", 32'(bus.dz), 32'(edz));
    chk("done_run_low", 32'(bus.div_run), 32'd0);
    @(negedge clk);
    chk("done_clear", 32'({bus.done0, bus.done1, bus.gnt0, bus.gnt1, bus.busy}), 32'd0);
    chk("quotient_hold", bus.quotient, eq);
  endtask

  initial begin
    bit gp;
    int n;

    vecs[0] = '{1'b0, 32'd100,         32'd7,  3, 32'd14,          32'd2,      1'b0};
    vecs[1] = '{1'b1, 32'd1000,        32'd10, 0, 32'd100,         32'd0,      1'b0};
    vecs[2] = '{1'b0, 32'd5,           32'd9,  1, 32'd0,           32'd5,      1'b0};
    vecs[3] = '{1'b1, 32'hFFFF_FFFF,   32'd2,  2, 32'h7FFF_FFFF,   32'd1,      1'b0};
    vecs[4] = '{1'b0, 32'd9,           32'd3,  0, 32'd3,           32'd0,      1'b0};
    vecs[5] = '{1'b1, 32'h0000_1234,   32'd0,  1, 32'hFFFF_FFFF,   32'h1234,   ZC};
    vecs[6] = '{1'b0, 32'd0,           32'd5,  4, 32'd0,           32'd0,      1'b0};

    rst = 1'b1;
    set_req(1'b0, 1'b0, 32'd0, 32'd0);
    set_req(1'b1, 1'b0, 32'd0, 32'd0);
    bus.div_ready     = 1'b0;
    bus.div_quotient  = 32'd0;
    bus.div_remainder = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", 32'({bus.busy, bus.div_rst, bus.div_run, bus.gnt0, bus.gnt1,
                           bus.done0, bus.done1, bus.dz}), 32'b0100_0000);
    chk("reset_quotient", bus.quotient, 32'd0);
    chk("reset_remainder", bus.remainder, 32'd0);
    chk("reset_div_dividend", bus.div_dividend, 32'd0);
    chk("reset_div_divisor", bus.div_divisor, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_reset_idle", 32'({bus.busy, bus.div_rst, bus.div_run}), 32'd0);

    // Ties right after reset: port0 first, then strict alternation.
    set_req(1'b0, 1'b1, 32'd100, 32'd7);
    set_req(1'b1, 1'b1, 32'd1000, 32'd10);
    for (int i = 0; i < 4; i++) begin
      wait_gnt(gp, n);
      chk("tie_order", 32'(gp), 32'(i % 2));
      chk("tie_latency", 32'(n), 32'd1);
      set_req(gp, 1'b0, 32'd0, 32'd0);
      finish_op(gp, 1, gp ? 32'd1000 : 32'd100, gp ? 32'd10 : 32'd7,
                gp ? 32'd100 : 32'd14, gp ? 32'd0 : 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      set_req(gp, 1'b1, gp ? 32'd1000 : 32'd100, gp ? 32'd10 : 32'd7);
    end
    set_req(1'b0, 1'b0, 32'd0, 32'd0);
    set_req(1'b1, 1'b0, 32'd0, 32'd0);
    @(negedge clk);

    for (int k = 0; k < 7; k++) begin
      set_req(vecs[k].p, 1'b1, vecs[k].a, vecs[k].b);
      wait_gnt(gp, n);
      chk("vec_gnt_port", 32'(gp), 32'(vecs[k].p));
      chk("vec_gnt_latency", 32'(n), 32'd1);
      set_req(vecs[k].p, 1'b0, 32'd0, 32'd0);
      finish_op(vecs[k].p, vecs[k].lat, vecs[k].a, vecs[k].b, vecs[k].q, vecs[k].r,
                vecs[k].dz, ZC && (vecs[k].b == 32'd0), 1'b0, 1'b0);
    end

    // req1 arrives while port0 is running: held pending, granted two cycles after done0.
    set_req(1'b0, 1'b1, 32'd100, 32'd7);
    wait_gnt(gp, n);
    chk("pend_first_port", 32'(gp), 32'd0);
    set_req(1'b0, 1'b0, 32'd0, 32'd0);
    finish_op(1'b0, 5, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_gnt(gp, n);
    chk("pend_second_port", 32'(gp), 32'd1);
    chk("pend_gnt_delay", 32'(n), 32'd1);
    set_req(1'b1, 1'b0, 32'd0, 32'd0);
    finish_op(1'b1, 2, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // div_ready outside RUN must not advance anything.
    bus.div_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ready_ignored", 32'({bus.busy, bus.done0, bus.done1, bus.div_run}), 32'd0);
    end
    bus.div_ready = 1'b0;
    set_req(1'b1, 1'b1, 32'd77, 32'd8);
    wait_gnt(gp, n);
    chk("stray_gnt_port", 32'(gp), 32'd1);
    set_req(1'b1, 1'b0, 32'd0, 32'd0);
    finish_op(1'b1, 1, 32'd77, 32'd8, 32'd9, 32'd5, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset in the 10th RUN cycle aborts silently; the next operation is unaffected.
    set_req(1'b0, 1'b1, 32'd100, 32'd7);
    wait_gnt(gp, n);
    set_req(1'b0, 1'b0, 32'd0, 32'd0);
    repeat (10) @(negedge clk);
    chk("abort_still_running", 32'(bus.div_run), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ctrl", 32'({bus.busy, bus.div_run, bus.div_rst, bus.done0, bus.done1}), 32'b00100);
    chk("abort_quotient", bus.quotient, 32'd0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", 32'({bus.done0, bus.done1, bus.busy, bus.div_rst}), 32'd0);
    end
    set_req(1'b0, 1'b1, 32'd9, 32'd3);
    wait_gnt(gp, n);
    chk("after_abort_port", 32'(gp), 32'd0);
    chk("after_abort_latency", 32'(n), 32'd1);
    set_req(1'b0, 1'b0, 32'd0, 32'd0);
    finish_op(1'b0, 2, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
